axi_sram_ctrl: RTL and testbench

AXI_SRAM_CTRL -- requirements
Module: axi_sram_ctrl

---
 rtl/axi_sram_ctrl_pkg.sv | 23 ++
 rtl/axi_sram_ctrl_arb.sv | 36 +++
 rtl/axi_sram_ctrl.sv | 152 +++++++++++++++
 tb/tb_axi_sram_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_ctrl_pkg.sv
// Shared SoC definitions for the AXI4-Lite SRAM controller: sizing defaults, responses, FSM states.
// The ZERO state exists only when AXI_SRAM_CTRL_ZEROIZE_EN is defined.
package axi_sram_ctrl_pkg;

   localparam int unsigned SRAM_DEPTH  = 4096;
   localparam int unsigned AXI_DATA_BW = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
      ZERO,
`endif
      RD_REQ,
      RD_WAIT,
      RD_RESP,
      WR_REQ,
      WR_RESP
   } state_t;

endpackage

// File: rtl/axi_sram_ctrl_arb.sv
// Two-requester arbiter: a lone request always wins; on a conflict the favoured side
// wins and the preference flips. Write is favoured after reset.
module axi_sram_ctrl_arb (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic wr_req,
   input  logic rd_req,
   output logic wr_gnt,
   output logic rd_gnt
);

   logic prio_wr;

   always_comb begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      if (en) begin
         if (wr_req && rd_req) begin
            wr_gnt = prio_wr;
            rd_gnt = !prio_wr;
         end else begin
            wr_gnt = wr_req;
            rd_gnt = rd_req;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prio_wr <= 1'b1;
      else if (en && wr_req && rd_req)
         prio_wr <= !prio_wr;
   end

endmodule

// File: rtl/axi_sram_ctrl.sv
// AXI4-Lite slave mapping single-beat transfers onto a one-cycle-latency SRAM port.
// Define AXI_SRAM_CTRL_ZEROIZE_EN to clear the whole SRAM after every reset (busy_o high meanwhile).
module axi_sram_ctrl
   import axi_sram_ctrl_pkg::*;
#(
   parameter  int unsigned AXI_ADDR_BW_p = 15,
   parameter  int unsigned AXI_DATA_BW_p = AXI_DATA_BW,
   parameter  int unsigned SRAM_DEPTH_p  = SRAM_DEPTH,
   localparam int unsigned AW            = $clog2(SRAM_DEPTH_p),
   localparam int unsigned BW            = AXI_DATA_BW_p / 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [AXI_ADDR_BW_p-1:0] awaddr,
   input  logic                     wvalid,
   output logic                     wready,
   input  logic [AXI_DATA_BW_p-1:0] wdata,
   input  logic [BW-1:0]            wstrb,
   output logic                     bvalid,
   input  logic                     bready,
   output logic [1:0]               bresp,
   input  logic                     arvalid,
   output logic                     arready,
   input  logic [AXI_ADDR_BW_p-1:0] araddr,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [AXI_DATA_BW_p-1:0] rdata,
   output logic [1:0]               rresp,
   output logic                     sram_req_o,
   output logic                     sram_we_o,
   output logic [AW-1:0]            sram_addr_o,
   output logic [AXI_DATA_BW_p-1:0] sram_wdata_o,
   output logic [BW-1:0]            sram_be_o,
   input  logic [AXI_DATA_BW_p-1:0] sram_rdata_i,
   output logic                     busy_o
);

   state_t                   state;
   logic [AW-1:0]            addr_q;
   logic [AXI_DATA_BW_p-1:0] wdata_q;
   logic [BW-1:0]            be_q;
   logic                     idle;
   logic                     wr_gnt;
   logic                     rd_gnt;
   logic                     zero_active;

   // Readies are combinational grants; gating with rst_i keeps them low during reset.
   assign idle = (state == IDLE) && !rst_i;

   axi_sram_ctrl_arb u_arb (
      .clk    (clk_i),
      .rst    (rst_i),
      .en     (idle),
      .wr_req (awvalid && wvalid),
      .rd_req (arvalid),
      .wr_gnt (wr_gnt),
      .rd_gnt (rd_gnt)
   );

   assign awready = wr_gnt;
   assign wready  = wr_gnt;
   assign arready = rd_gnt;
   assign bresp   = RESP_OKAY;
   assign rresp   = RESP_OKAY;

`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
   localparam state_t        RST_STATE = ZERO;
   localparam logic [AW-1:0] LAST_IDX  = AW'(SRAM_DEPTH_p - 1);
   logic [AW-1:0] zero_idx;

   assign zero_active  = (state == ZERO) && !rst_i;
   assign sram_addr_o  = zero_active ? zero_idx : addr_q;
   assign sram_wdata_o = zero_active ? '0 : wdata_q;
   assign sram_be_o    = zero_active ? '1 : be_q;
`else
   localparam state_t RST_STATE = IDLE;

   assign zero_active  = 1'b0;
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign sram_be_o    = be_q;
`endif

   assign busy_o     = zero_active;
   assign sram_req_o = zero_active || (state == RD_REQ) || (state == WR_REQ);
   assign sram_we_o  = zero_active || (state == WR_REQ);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= RST_STATE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata   <= '0;
         rvalid  <= 1'b0;
         bvalid  <= 1'b0;
`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
         zero_idx <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (wr_gnt) begin
                  addr_q  <= awaddr[AW+1:2];
                  wdata_q <= wdata;
                  be_q    <= wstrb;
                  state   <= WR_REQ;
               end else if (rd_gnt) begin
                  addr_q <= araddr[AW+1:2];
                  state  <= RD_REQ;
               end
            end
`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
            ZERO: begin
               if (zero_idx == LAST_IDX) begin
                  zero_idx <= '0;
                  state    <= IDLE;
               end else begin
                  zero_idx <= zero_idx + 1'b1;
               end
            end
`endif
            RD_REQ:  state <= RD_WAIT;
            RD_WAIT: begin
               rdata  <= sram_rdata_i;
               rvalid <= 1'b1;
               state  <= RD_RESP;
            end
            RD_RESP: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            WR_REQ: begin
               bvalid <= 1'b1;
               state  <= WR_RESP;
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Bench for axi_sram_ctrl: behavioural SRAM, transaction-level reference model checked every cycle,
// directed cases plus randomized traffic. Also covers the AXI_SRAM_CTRL_ZEROIZE_EN build.
`timescale 1ns/1ps
module tb_axi_sram_ctrl;

   localparam int ABW   = 15;
   localparam int DBW   = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
   localparam int ZCYC = DEPTH;
`else
   localparam int ZCYC = 0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           awvalid, awready, wvalid, wready, bvalid, bready;
   logic           arvalid, arready, rvalid, rready;
   logic [ABW-1:0] awaddr, araddr;
   logic [DBW-1:0] wdata, rdata;
   logic [3:0]     wstrb;
   logic [1:0]     bresp, rresp;
   logic           sram_req, sram_we, busy;
   logic [AW-1:0]  sram_addr;
   logic [DBW-1:0] sram_wdata, sram_rdata;
   logic [3:0]     sram_be;

   axi_sram_ctrl #(
      .AXI_ADDR_BW_p (ABW),
      .AXI_DATA_BW_p (DBW),
      .SRAM_DEPTH_p  (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .awvalid      (awvalid),
      .awready      (awready),
      .awaddr       (awaddr),
      .wvalid       (wvalid),
      .wready       (wready),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .bvalid       (bvalid),
      .bready       (bready),
      .bresp        (bresp),
      .arvalid      (arvalid),
      .arready      (arready),
      .araddr       (araddr),
      .rvalid       (rvalid),
      .rready       (rready),
      .rdata        (rdata),
      .rresp        (rresp),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_be_o    (sram_be),
      .sram_rdata_i (sram_rdata),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: one-cycle read latency, byte-enabled writes.
   logic [DBW-1:0] mem [DEPTH];
   logic [DBW-1:0] rd_q = '0;
   assign sram_rdata = rd_q;
   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            rd_q <= mem[sram_addr];
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one transaction at a time, memory as a plain array.
   logic [DBW-1:0] model_mem [DEPTH];
   bit             prio_wr, inflight, rd_act, wr_act;
   int             hs_cyc, req_cyc, zero_left;
   bit             exp_we;
   logic [AW-1:0]  exp_addr;
   logic [DBW-1:0] exp_wd, exp_rdata;
   logic [3:0]     exp_be;
   bit             m_wrq, m_rdq, m_eaw, m_ear, m_erv, m_ebv;
   int             idx_a;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_outputs", {awready, wready, arready, bvalid, rvalid, sram_req, busy}, 0);
         chk("rst_data", {rdata, bresp, rresp}, 0);
         inflight = 0; rd_act = 0; wr_act = 0; prio_wr = 1;
         req_cyc = -100; hs_cyc = -100; zero_left = ZCYC;
         if (ZCYC > 0) for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else begin
         m_wrq = awvalid && wvalid;
         m_rdq = arvalid;
         m_eaw = 0; m_ear = 0;
         if (zero_left == 0 && !inflight) begin
            if (m_wrq && m_rdq) begin m_eaw = prio_wr; m_ear = !prio_wr; end
            else begin m_eaw = m_wrq; m_ear = m_rdq; end
         end
         chk("awready", awready, m_eaw);
         chk("wready", wready, m_eaw);
         chk("arready", arready, m_ear);
         if (zero_left > 0) begin
            chk("zero_busy", busy, 1);
            chk("zero_req_we", {sram_req, sram_we}, 2'b11);
            chk("zero_addr", sram_addr, DEPTH - zero_left);
            chk("zero_data_be", {sram_wdata, sram_be}, {32'h0, 4'hF});
            zero_left--;
         end else begin
            chk("busy", busy, 0);
            chk("sram_req", sram_req, cyc == req_cyc);
            if (cyc == req_cyc) begin
               chk("sram_we", sram_we, exp_we);
               chk("sram_addr", sram_addr, exp_addr);
               if (exp_we) chk("sram_wdata_be", {sram_wdata, sram_be}, {exp_wd, exp_be});
            end
         end
         m_erv = rd_act && (cyc >= hs_cyc + 3);
         m_ebv = wr_act && (cyc >= hs_cyc + 2);
         chk("rvalid", rvalid, m_erv);
         chk("bvalid", bvalid, m_ebv);
         if (m_erv) begin chk("rdata", rdata, exp_rdata); chk("rresp", rresp, 0); end
         if (m_ebv) chk("bresp", bresp, 0);
         if (m_erv && rready) begin rd_act = 0; inflight = 0; end
         if (m_ebv && bready) begin wr_act = 0; inflight = 0; end
         if (m_eaw) begin
            idx_a = int'(awaddr[AW+1:2]);
            hs_cyc = cyc; req_cyc = cyc + 1; exp_we = 1;
            exp_addr = awaddr[AW+1:2]; exp_wd = wdata; exp_be = wstrb;
            for (int b = 0; b < 4; b++)
               if (wstrb[b]) model_mem[idx_a][8*b +: 8] = wdata[8*b +: 8];
            wr_act = 1; inflight = 1;
            if (m_rdq) prio_wr = 0;
         end else if (m_ear) begin
            hs_cyc = cyc; req_cyc = cyc + 1; exp_we = 0;
            exp_addr = araddr[AW+1:2];
            exp_rdata = model_mem[araddr[AW+1:2]];
            rd_act = 1; inflight = 1;
            if (m_wrq) prio_wr = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      bit done = 0;
      n = 0;
      for (int i = 0; i < DEPTH + 20 && !done; i++) begin
         @(negedge clk);
         if (busy) n++; else done = 1;
         step();
      end
   endtask

   task automatic pulse_rst();
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic wait_resp(input bit is_rd, input int hc, output logic [DBW-1:0] d, output int lat);
      lat = -1;
      d = '0;
      for (int i = 0; i < 60 && lat < 0; i++) begin
         @(negedge clk);
         if (is_rd ? rvalid : bvalid) begin lat = cyc - hc; d = rdata; end
         step();
      end
      if (lat < 0) chk("resp_timeout", 0, 1);
   endtask

   task automatic ar_handshake(input logic [ABW-1:0] a, output int hc);
      bit done = 0;
      araddr = a; arvalid = 1; hc = -1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (arready) begin done = 1; hc = cyc; end
         step();
      end
      arvalid = 0;
      if (!done) chk("ar_handshake_timeout", 0, 1);
   endtask

   task automatic do_read(input logic [ABW-1:0] a, output logic [DBW-1:0] d, output int lat);
      int hc;
      rready = 1;
      ar_handshake(a, hc);
      wait_resp(1, hc, d, lat);
   endtask

   task automatic do_write(input logic [ABW-1:0] a, input logic [DBW-1:0] d, input logic [3:0] s,
                           input bit br, output int lat, output int idx);
      bit done = 0;
      int hc = -1;
      logic [DBW-1:0] dummy;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = br;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (awready && wready) begin done = 1; hc = cyc; end
         step();
      end
      awvalid = 0; wvalid = 0;
      if (!done) chk("aw_handshake_timeout", 0, 1);
      @(negedge clk);
      idx = (sram_req && sram_we) ? int'(sram_addr) : -1;
      step();
      wait_resp(0, hc, dummy, lat);
   endtask

   int             n, lat, idx, nw, nr, seen;
   logic [DBW-1:0] d;
   logic [31:0]    gword;
   bit             whs, rhs, drain;

   initial begin
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'hFFFF_FFFF; model_mem[i] = 32'hFFFF_FFFF; end
      repeat (3) @(posedge clk);
      #1 rst = 0;
      count_busy(n);
      chk("busy_cycles_after_reset", n, ZCYC);

`ifdef AXI_SRAM_CTRL_ZEROIZE_EN
      pulse_rst();
      repeat (7) step();
      pulse_rst();
      arvalid = 1; araddr = 15'h0020;
      count_busy(n);
      chk("busy_cycles_after_restart", n, DEPTH);
      do_read(15'h0020, d, lat);
      chk("zeroized_word", d, 32'h0);
`endif

      // Single write then read of the same word, with fixed latencies.
      do_write(15'h4010, 32'hDEAD_BEEF, 4'hF, 1, lat, idx);
      chk("wr_sram_index", idx, 4);
      chk("wr_bvalid_latency", lat, 2);
      do_read(15'h4010, d, lat);
      chk("rd_data_deadbeef", d, 32'hDEAD_BEEF);
      chk("rd_rvalid_latency", lat, 3);

      // Partial strobes, aliased address bits, and a zero-strobe write.
      do_write(15'h0000, 32'hFFFF_FFFF, 4'hF, 1, lat, idx);
      do_write(15'h0000, 32'h1234_5678, 4'h3, 1, lat, idx);
      do_read(15'h0000, d, lat);
      chk("partial_strobe", d, 32'hFFFF_5678);
      do_read(15'h7FC3, d, lat);
      chk("alias_upper_low_bits", d, 32'hFFFF_5678);
      do_write(15'h000C, 32'hAAAA_AAAA, 4'hF, 1, lat, idx);
      do_write(15'h000C, 32'h5555_5555, 4'h0, 1, lat, idx);
      chk("zero_strobe_index", idx, 3);
      do_read(15'h000C, d, lat);
      chk("zero_strobe_unchanged", d, 32'hAAAA_AAAA);

      // Response back-pressure while another read waits.
      rready = 0;
      ar_handshake(15'h0010, n);
      arvalid = 1; araddr = 15'h0000;
      wait_resp(1, n, d, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rvalid", rvalid, 1);
         chk("hold_rdata", rdata, 32'hDEAD_BEEF);
         chk("hold_arready", arready, 0);
         step();
      end
      do_read(15'h0000, d, lat);
      chk("read_after_hold", d, 32'hFFFF_5678);

      // Conflicting requests from a fresh reset: alternating priority.
      pulse_rst();
      count_busy(n);
      gword = '0; nw = 0; nr = 0;
      awaddr = 15'h0014; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 15'h0018; arvalid = 1; rready = 1; bready = 1;
      for (int i = 0; i < 80 && (nw < 2 || nr < 2); i++) begin
         @(negedge clk);
         whs = awvalid && awready;
         rhs = arvalid && arready;
         if (whs) gword = {gword[23:0], 8'h57};
         if (rhs) gword = {gword[23:0], 8'h52};
         step();
         if (whs) begin
            nw++;
            wdata = 32'hC0DE_0000 + nw;
            if (nw >= 2) begin awvalid = 0; wvalid = 0; end
         end
         if (rhs) begin nr++; if (nr >= 2) arvalid = 0; end
      end
      chk("grant_order_WRWR", gword, 32'h5752_5752);
      repeat (8) step();

      // Reset while a write response is pending.
      do_write(15'h0008, 32'h7777_7777, 4'hF, 0, lat, idx);
      #2 rst = 1;
      #1 chk("async_bvalid_drop", bvalid, 0);
      @(posedge clk);
      #1 rst = 0;
      count_busy(n);
      bready = 1; seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bvalid) seen++;
         step();
      end
      chk("no_stale_bvalid", seen, 0);

      // Randomized traffic, then drain outstanding requests.
      for (int c = 0; c < 800; c++) begin
         drain = (c >= 700);
         if (!awvalid && (drain ? wvalid : ($urandom_range(0, 3) == 0))) begin
            awvalid = 1; awaddr = ABW'($urandom);
         end
         if (!wvalid && (drain ? awvalid : ($urandom_range(0, 3) == 0))) begin
            wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
         end
         if (!arvalid && !drain && $urandom_range(0, 3) == 0) begin
            arvalid = 1; araddr = ABW'($urandom);
         end
         rready = drain || ($urandom_range(0, 2) != 0);
         bready = drain || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         whs = awvalid && wvalid && awready && wready;
         rhs = arvalid && arready;
         step();
         if (whs) begin awvalid = 0; wvalid = 0; end
         if (rhs) arvalid = 0;
      end
      chk("random_drained", {awvalid, wvalid, arvalid}, 0);

      for (int i = 0; i < DEPTH; i++)
         do_read(ABW'(($urandom_range(0, 511) << 6) | (i << 2) | $urandom_range(0, 3)), d, lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
